uart_tx_frame_sched: RTL and testbench

Schedules framed transfers over a single shared uart_tx transmitter for NREQ requesters, such as down-sample result channels. It arbitrates round-robin and captures the winner's WORD_BYTES-byte word. It then drives uart_tx one byte at a time (tx_start/din, pacing on tx_done_tick): a header byte, the data bytes MSB first, and an optional XOR checksum byte.

---
 rtl/uart_tx_frame_sched_pkg.sv | 33 +++
 rtl/uart_tx_frame_sched_rr_arbiter.sv | 36 +++
 rtl/uart_tx_frame_sched.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_frame_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_sched_pkg.sv
// Shared state encoding and sizing helpers for the uart_tx frame scheduler.
// TX_FRAME_CHECKSUM_EN appends an XOR checksum byte to every frame.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } frame_state_t;

    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

`ifdef TX_FRAME_CHECKSUM_EN
    localparam int CKSUM_BYTES = 1;
`else
    localparam int CKSUM_BYTES = 0;
`endif

    // Header + data bytes (+ checksum when enabled).
    function automatic int frame_len(input int word_bytes);
        return 1 + word_bytes + CKSUM_BYTES;
    endfunction

    function automatic int idx_width(input int word_bytes);
        return $clog2(word_bytes + 2);
    endfunction

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_frame_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after i_ptr, wrapping.
// Reusable for any shared resource; NREQ=1 always grants requester 0.
module rr_arbiter
    import uart_frame_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);

    int w_idx;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        if (i_en) begin
            for (int i = 0; i < NREQ; i++) begin
                w_idx = (int'(i_ptr) + i) % NREQ;
                if (!o_any && i_req[w_idx]) begin
                    o_any          = 1'b1;
                    o_grant[w_idx] = 1'b1;
                    o_id           = IDW'(w_idx);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_sched.sv
// Round-robin frame scheduler feeding one shared uart_tx: header, data MSB first,
// optional XOR checksum byte (TX_FRAME_CHECKSUM_EN).
module uart_tx_frame_sched
    import uart_frame_pkg::*;
#(
    parameter int         NREQ       = 2,
    parameter int         WORD_BYTES = 2,
    parameter logic [3:0] HDR_TAG    = HDR_TAG_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*WORD_BYTES*8-1:0]   req_data,
    output logic [NREQ-1:0]                req_ready,
    output logic                           tx_start,
    output logic [7:0]                     tx_din,
    input  logic                           tx_done_tick,
    output logic                           busy,
    output logic                           frame_done_tick
);

    localparam int IDW   = id_width(NREQ);
    localparam int WBITS = WORD_BYTES * 8;
    localparam int IDXW  = idx_width(WORD_BYTES);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(frame_len(WORD_BYTES) - 1);
    localparam logic [IDW-1:0]  ID_MAX   = IDW'(NREQ - 1);
`ifdef TX_FRAME_CHECKSUM_EN
    localparam logic [IDXW-1:0] IDX_LAST_DATA = IDXW'(WORD_BYTES);
`endif

    frame_state_t      r_state;
    logic [NREQ-1:0]   r_req_ready;
    logic              r_tx_start;
    logic [7:0]        r_tx_din;
    logic              r_busy;
    logic              r_frame_done;
    logic [IDXW-1:0]   r_idx;
    logic [IDW-1:0]    r_ptr;
    logic [WBITS-1:0]  r_word;
`ifdef TX_FRAME_CHECKSUM_EN
    logic [7:0]        r_cksum;
`endif

    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_gid;
    logic              w_any;
    logic [WBITS-1:0]  w_word;
    logic [3:0]        w_id4;
    logic [7:0]        w_header;
    logic [IDW-1:0]    w_ptr_next;
    logic [7:0]        w_top;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (r_state == ST_IDLE),
        .o_grant (w_grant),
        .o_id    (w_gid),
        .o_any   (w_any)
    );

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_word = w_word | req_data[i*WBITS +: WBITS];
            end
        end
    end

    always_comb begin
        w_id4            = '0;
        w_id4[IDW-1:0]   = w_gid;
    end

    assign w_header   = {HDR_TAG, w_id4};
    assign w_ptr_next = (w_gid == ID_MAX) ? '0 : w_gid + IDW'(1);
    // The captured word is shifted left as bytes leave, so the next data byte is always on top.
    assign w_top      = r_word[WBITS-1 -: 8];

    // IDLE: arbitrate/capture | SEND: issue start | WAIT: await tx_done_tick | DONE: frame_done_tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= '0;
            r_tx_start   <= 1'b0;
            r_tx_din     <= 8'h00;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_idx        <= '0;
            r_ptr        <= '0;
            r_word       <= '0;
`ifdef TX_FRAME_CHECKSUM_EN
            r_cksum      <= 8'h00;
`endif
        end else begin
            r_req_ready  <= '0;
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_req_ready <= w_grant;
                        r_word      <= w_word;
                        r_ptr       <= w_ptr_next;
                        r_tx_din    <= w_header;
                        r_idx       <= '0;
`ifdef TX_FRAME_CHECKSUM_EN
                        r_cksum     <= w_header;
`endif
                        r_busy      <= 1'b1;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_tx_start <= 1'b1;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done_tick) begin
                        if (r_idx == IDX_LAST) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + IDXW'(1);
                            r_state <= ST_SEND;
`ifdef TX_FRAME_CHECKSUM_EN
                            if (r_idx == IDX_LAST_DATA) begin
                                r_tx_din <= r_cksum;
                            end else begin
                                r_tx_din <= w_top;
                                r_cksum  <= r_cksum ^ w_top;
                                r_word   <= r_word << 8;
                            end
`else
                            r_tx_din <= w_top;
                            r_word   <= r_word << 8;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = r_req_ready;
    assign tx_start        = r_tx_start;
    assign tx_din          = r_tx_din;
    assign busy            = r_busy;
    assign frame_done_tick = r_frame_done;

endmodule

// File: tb/tb_uart_tx_frame_sched.sv
// Self-checking bench for uart_tx_frame_sched: emulated uart_tx, round-robin and
// frame-content reference model. Honours TX_FRAME_CHECKSUM_EN like the design.
module tb_uart_tx_frame_sched;

    localparam int NREQ = 2;
    localparam int WB   = 2;
`ifdef TX_FRAME_CHECKSUM_EN
    localparam int FLEN = 1 + WB + 1;
`else
    localparam int FLEN = 1 + WB;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WB*8-1:0]  req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  tx_start;
    logic [7:0]            tx_din;
    logic                  tx_done_tick = 1'b0;
    logic                  busy;
    logic                  frame_done_tick;

    uart_tx_frame_sched #(.NREQ(NREQ), .WORD_BYTES(WB)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .tx_start        (tx_start),
        .tx_din          (tx_din),
        .tx_done_tick    (tx_done_tick),
        .busy            (busy),
        .frame_done_tick (frame_done_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [WB*8-1:0] wd [NREQ];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] all_got[$];
    int   grants[$];
    int   ready_cnt [NREQ];
    int   obs = 0, ptr_m = 0, frames = 0, cnt = 0;
    int   ready_obs = 0, last_done_obs = 0, last_fd_obs = 0;
    int   dly_min = 20, dly_max = 20;
    bit   in_flight = 0, frame_active = 0, first_byte = 0;
    bit   hold_mode = 0, spur_en = 0, gen_en = 0;
    logic [7:0] held = 8'h00;

    task automatic set_word(input int i, input logic [WB*8-1:0] w);
        wd[i] = w;
        req_data[i*WB*8 +: WB*8] = w;
    endtask

    // Frame content from first principles: tag/id header, word MSB first, XOR of all.
    task automatic build_frame(input int id, input logic [WB*8-1:0] w);
        logic [7:0] hdr, ck, b;
        hdr = {4'hA, 4'(id)};
        ck = hdr;
        exp_q.push_back(hdr);
        for (int k = WB - 1; k >= 0; k--) begin
            b = w[k*8 +: 8];
            ck = ck ^ b;
            exp_q.push_back(b);
        end
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(ck);
`endif
    endtask

    task automatic cycle();
        bit start_now;
        bit mism;
        int g;
        logic [NREQ-1:0] oh;
        @(posedge clk); #1; obs++;
        tx_done_tick = 1'b0;
        start_now = 1'b0;

        if (req_ready !== '0) begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
            checks++;
            if (g < 0 || frame_active) begin
                failures++;
                $display("FAIL grant_unexpected ready=%b valid=%b active=%0d", req_ready, req_valid, frame_active);
            end else begin
                oh = '0;
                oh[g] = 1'b1;
                if (req_ready !== oh) begin
                    failures++;
                    $display("FAIL grant_order ready=%b expected=%b", req_ready, oh);
                end
                grants.push_back(g);
                build_frame(g, wd[g]);
                ready_cnt[g]++;
                ptr_m = (g + 1) % NREQ;
                frame_active = 1;
                ready_obs = obs;
                first_byte = 1;
                if (hold_mode) begin
                    if (last_fd_obs > 0) begin
                        checks++;
                        if (obs != last_fd_obs + 2) begin
                            failures++;
                            $display("FAIL regrant_latency got=%0d expected=%0d", obs - last_fd_obs, 2);
                        end
                    end
                    set_word(g, (WB*8)'($urandom()));
                end else begin
                    req_valid[g] = 1'b0;
                end
            end
        end

        if (tx_start === 1'b1) begin
            start_now = 1'b1;
            checks++;
            if (in_flight || !frame_active) begin
                failures++;
                $display("FAIL start_overlap in_flight=%0d active=%0d", in_flight, frame_active);
            end
            checks++;
            if (first_byte ? (obs != ready_obs + 1) : (obs != last_done_obs + 2)) begin
                failures++;
                $display("FAIL start_latency got_gap=%0d expected_gap=%0d first=%0d",
                         first_byte ? obs - ready_obs : obs - last_done_obs, first_byte ? 1 : 2, first_byte);
            end
            first_byte = 0;
            got_q.push_back(tx_din);
            all_got.push_back(tx_din);
            held = tx_din;
            in_flight = 1;
            cnt = int'($urandom_range(dly_max, dly_min));
        end else if (in_flight) begin
            checks++;
            if (tx_din !== held) begin
                failures++;
                $display("FAIL din_stable got=%h expected=%h", tx_din, held);
            end
            cnt--;
            if (cnt <= 0) begin
                tx_done_tick = 1'b1;
                in_flight = 0;
                last_done_obs = obs;
            end
        end
        if (!start_now && !in_flight && tx_done_tick == 1'b0 && spur_en && $urandom_range(3, 0) == 0)
            tx_done_tick = 1'b1;

        checks++;
        if (busy !== frame_active) begin
            failures++;
            $display("FAIL busy got=%b expected=%b", busy, frame_active);
        end

        if (frame_done_tick === 1'b1) begin
            checks++;
            if (!frame_active || obs != last_done_obs + 1) begin
                failures++;
                $display("FAIL frame_done_timing active=%0d gap=%0d expected_gap=1", frame_active, obs - last_done_obs);
            end
            mism = (got_q.size() != exp_q.size());
            if (!mism) foreach (got_q[k]) if (got_q[k] !== exp_q[k]) mism = 1;
            checks++;
            if (mism) begin
                failures++;
                $display("FAIL frame_bytes got=%p expected=%p", got_q, exp_q);
            end
            frames++;
            frame_active = 0;
            last_fd_obs = obs;
            got_q.delete();
            exp_q.delete();
        end

        if (gen_en)
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(5, 0) == 0) begin
                    set_word(i, (WB*8)'($urandom()));
                    req_valid[i] = 1'b1;
                end
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_until_frames(input int target, input int budget, input string tag);
        int n = 0;
        while (frames < target && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (frames < target) begin
            failures++;
            $display("FAIL %s_timeout frames=%0d expected=%0d", tag, frames, target);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tx_done_tick = 1'b0;
        hold_mode = 0; spur_en = 0; gen_en = 0;
        in_flight = 0; frame_active = 0; first_byte = 0;
        got_q.delete(); exp_q.delete(); all_got.delete(); grants.delete();
        ptr_m = 0; frames = 0; last_fd_obs = 0;
        for (int i = 0; i < NREQ; i++) ready_cnt[i] = 0;
        repeat (2) begin @(posedge clk); #1; obs++; end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1; obs++;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL rst_req_ready got=%b expected=0", req_ready); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start got=%b expected=0", tx_start); end
        checks++; if (tx_din !== 8'h00) begin failures++; $display("FAIL rst_tx_din got=%h expected=00", tx_din); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b expected=0", busy); end
        checks++; if (frame_done_tick !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b expected=0", frame_done_tick); end
        do_reset();
        run_idle(5);
        checks++; if (frames != 0 || tx_din !== 8'h00) begin failures++; $display("FAIL idle_after_reset frames=%0d din=%h expected=0/00", frames, tx_din); end
    endtask

    task automatic test_single();
        logic [7:0] e[$];
        do_reset();
        dly_min = 20; dly_max = 20;
        set_word(0, 16'h1234);
        req_valid = 2'b01;
        run_until_frames(1, 300, "single");
        run_idle(10);
        e = '{8'hA0, 8'h12, 8'h34};
`ifdef TX_FRAME_CHECKSUM_EN
        e.push_back(8'h86);
`endif
        checks++; if (all_got != e) begin failures++; $display("FAIL single_bytes got=%p expected=%p", all_got, e); end
        checks++; if (ready_cnt[0] != 1) begin failures++; $display("FAIL single_ready_count got=%0d expected=1", ready_cnt[0]); end
        checks++; if (frames != 1) begin failures++; $display("FAIL single_frame_count got=%0d expected=1", frames); end
    endtask

    task automatic test_pair();
        logic [7:0] e[$];
        int fd1;
        do_reset();
        dly_min = 20; dly_max = 20;
        set_word(0, 16'h1234);
        set_word(1, 16'hBEEF);
        req_valid = 2'b11;
        run_until_frames(1, 300, "pair1");
        fd1 = obs;
        run_until_frames(2, 300, "pair2");
        run_idle(5);
        e = '{8'hA0, 8'h12, 8'h34};
`ifdef TX_FRAME_CHECKSUM_EN
        e.push_back(8'h86);
`endif
        e.push_back(8'hA1); e.push_back(8'hBE); e.push_back(8'hEF);
`ifdef TX_FRAME_CHECKSUM_EN
        e.push_back(8'hF0);
`endif
        checks++; if (all_got != e) begin failures++; $display("FAIL pair_bytes got=%p expected=%p", all_got, e); end
        checks++; if (ready_obs != fd1 + 2) begin failures++; $display("FAIL pair_regrant gap=%0d expected=2", ready_obs - fd1); end
    endtask

    task automatic test_rr_fairness();
        int e[4] = '{0, 1, 0, 1};
        bit bad;
        do_reset();
        dly_min = 1; dly_max = 8;
        hold_mode = 1;
        set_word(0, (WB*8)'($urandom()));
        set_word(1, (WB*8)'($urandom()));
        req_valid = 2'b11;
        run_until_frames(4, 600, "rr");
        req_valid = '0;
        hold_mode = 0;
        run_idle(10);
        bad = (grants.size() != 4);
        if (!bad) for (int k = 0; k < 4; k++) if (grants[k] != e[k]) bad = 1;
        checks++; if (bad) begin failures++; $display("FAIL rr_order got=%p expected=0,1,0,1", grants); end
    endtask

    task automatic test_spurious_done();
        do_reset();
        dly_min = 3; dly_max = 10;
        spur_en = 1;
        run_idle(20);
        checks++; if (frames != 0 || all_got.size() != 0) begin failures++; $display("FAIL spur_idle frames=%0d bytes=%0d expected=0", frames, all_got.size()); end
        set_word(1, (WB*8)'($urandom()));
        req_valid = 2'b10;
        run_until_frames(1, 400, "spur1");
        set_word(0, (WB*8)'($urandom()));
        req_valid = 2'b01;
        run_until_frames(2, 400, "spur2");
        spur_en = 0;
        run_idle(5);
        checks++; if (all_got.size() != 2 * FLEN) begin failures++; $display("FAIL spur_byte_count got=%0d expected=%0d", all_got.size(), 2 * FLEN); end
    endtask

    task automatic test_midframe_reset();
        int n = 0;
        do_reset();
        dly_min = 6; dly_max = 12;
        set_word(0, (WB*8)'($urandom()));
        req_valid = 2'b01;
        while (!(got_q.size() == 2 && in_flight) && n < 300) begin cycle(); n++; end
        checks++; if (n >= 300) begin failures++; $display("FAIL midreset_reach_timeout bytes=%0d expected=2", got_q.size()); end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0 || tx_start !== 1'b0 || tx_din !== 8'h00 || busy !== 1'b0 || frame_done_tick !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs ready=%b start=%b din=%h busy=%b fdone=%b expected all zero",
                     req_ready, tx_start, tx_din, busy, frame_done_tick);
        end
        #1;
        do_reset();
        set_word(1, (WB*8)'($urandom()));
        req_valid = 2'b10;
        run_until_frames(1, 400, "midreset");
        checks++; if (all_got.size() == 0 || all_got[0] !== 8'hA1) begin failures++; $display("FAIL midreset_header got=%p expected first=a1", all_got); end
    endtask

    task automatic test_random();
        int n = 0;
        int sum;
        do_reset();
        dly_min = 1; dly_max = 15;
        gen_en = 1;
        spur_en = 1;
        run_until_frames(16, 8000, "random");
        gen_en = 0;
        while ((req_valid != '0 || frame_active) && n < 2000) begin cycle(); n++; end
        spur_en = 0;
        run_idle(5);
        sum = 0;
        for (int i = 0; i < NREQ; i++) sum += ready_cnt[i];
        checks++; if (sum != frames || n >= 2000) begin failures++; $display("FAIL random_accounting grants=%0d frames=%0d drain=%0d", sum, frames, n); end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin wd[i] = '0; ready_cnt[i] = 0; end
        test_reset();
        test_single();
        test_pair();
        test_rr_fairness();
        test_spurious_done();
        test_midframe_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
